uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_param_if.sv | 24 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_param.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } rx_state_e;

    localparam int UART_CLK_PER_BIT_115200 = 868;

    // Never returns less than 1, so counters for tiny ranges stay legal vectors.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: data word, valid/ready and status sidebands.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 i_rx_ready;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_overrun;
    logic                 o_busy;

    modport master (
        output o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_overrun, o_busy,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_overrun, o_busy,
        output i_rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX pin; resets to the idle-high level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with framing/overrun detection and a valid/ready output register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT_115200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_rx_serial,
    uart_rx_param_if.master rx_if
);

    localparam int CNT_W = clog2(CLK_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLK_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("uart_rx_param: illegal parameter value");
    end

    logic                 rxS;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clkCnt_q, clkCnt_d;
    logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
    logic                 stopIdx_q, stopIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stopErr_q, stopErr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overrun_q, overrun_d;
    logic                 complete;
    logic                 frameErrNow;
`ifdef UART_RX_PARITY_EN
    logic                 parErr_q, parErr_d;
    logic                 parityErr_q, parityErr_d;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_rx_serial),
        .o_sync  (rxS)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            clkCnt_q   <= '0;
            bitIdx_q   <= '0;
            stopIdx_q  <= 1'b0;
            shift_q    <= '0;
            stopErr_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clkCnt_q   <= clkCnt_d;
            bitIdx_q   <= bitIdx_d;
            stopIdx_q  <= stopIdx_d;
            shift_q    <= shift_d;
            stopErr_q  <= stopErr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parErr_q    <= 1'b0;
            parityErr_q <= 1'b0;
        end else begin
            parErr_q    <= parErr_d;
            parityErr_q <= parityErr_d;
        end
    end
`endif

    // Data bits shift in from the MSB end, so the first (LSB) bit lands at index 0 after the last shift.
    always_comb begin
        state_d     = state_q;
        clkCnt_d    = clkCnt_q;
        bitIdx_d    = bitIdx_q;
        stopIdx_d   = stopIdx_q;
        shift_d     = shift_q;
        stopErr_d   = stopErr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frameErr_d  = frameErr_q;
        overrun_d   = 1'b0;
        complete    = 1'b0;
        frameErrNow = stopErr_q | ~rxS;
`ifdef UART_RX_PARITY_EN
        parErr_d    = parErr_q;
        parityErr_d = parityErr_q;
`endif

        if (valid_q && rx_if.i_rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxS) begin
                    clkCnt_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (clkCnt_q == CNT_HALF) begin
                    clkCnt_d  = '0;
                    bitIdx_d  = '0;
                    stopIdx_d = 1'b0;
                    stopErr_d = 1'b0;
                    state_d   = rxS ? IDLE : DATA;
                end else begin
                    clkCnt_d = clkCnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (clkCnt_q == CNT_LAST) begin
                    clkCnt_d = '0;
                    shift_d  = {rxS, shift_q[DATA_BITS-1:1]};
                    if (bitIdx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                    end
                end else begin
                    clkCnt_d = clkCnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clkCnt_q == CNT_LAST) begin
                    clkCnt_d = '0;
                    parErr_d = (^shift_q) ^ rxS ^ 1'(PARITY_ODD);
                    state_d  = STOP;
                end else begin
                    clkCnt_d = clkCnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (clkCnt_q == CNT_LAST) begin
                    clkCnt_d  = '0;
                    stopErr_d = frameErrNow;
                    if (stopIdx_q == STOP_LAST) begin
                        complete = 1'b1;
                    end else begin
                        stopIdx_d = 1'b1;
                    end
                end else begin
                    clkCnt_d = clkCnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An errored frame parks in RECOVER so a held-low break yields only one word.
        if (complete) begin
            state_d = frameErrNow ? RECOVER : IDLE;
            if (!valid_q || rx_if.i_rx_ready) begin
                data_d     = shift_q;
                frameErr_d = frameErrNow;
                valid_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                parityErr_d = parErr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_if.o_rx_data   = data_q;
    assign rx_if.o_rx_valid  = valid_q;
    assign rx_if.o_frame_err = frameErr_q;
    assign rx_if.o_overrun   = overrun_q;
    assign rx_if.o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_parity_err = parityErr_q;
`else
    assign rx_if.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7-bit/2-stop instance on short bit periods.
module tb_uart_rx_param;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT_NOM = 155 + (PAR_EN ? CPB : 0);

    logic clk = 1'b0;
    logic rstA, rstB;
    logic serialA, serialB;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   riseA = 0;
    int   overrunA = 0;
    int   overrunB = 0;
    logic prevValidA = 1'b0;
    logic [8:0] dataQA[$];
    logic       ferrQA[$];
    logic       perrQA[$];
    logic [8:0] dataQB[$];
    logic       ferrQB[$];

    uart_rx_param_if #(.DATA_BITS(8)) ifA ();
    uart_rx_param_if #(.DATA_BITS(7)) ifB ();

    uart_rx_param #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0),
        .SYNC_STAGES (2)
    ) dutA (
        .i_clk       (clk),
        .i_rst_n     (rstA),
        .i_rx_serial (serialA),
        .rx_if       (ifA.master)
    );

    uart_rx_param #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (7),
        .STOP_BITS   (2),
        .PARITY_ODD  (0),
        .SYNC_STAGES (3)
    ) dutB (
        .i_clk       (clk),
        .i_rst_n     (rstB),
        .i_rx_serial (serialB),
        .rx_if       (ifB.master)
    );

    always #5 clk = ~clk;

    // Record every accepted word, the cycle a new word appears, and overrun pulses.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (ifA.o_rx_valid && !prevValidA) riseA = cycle;
        prevValidA = ifA.o_rx_valid;
        if (ifA.o_rx_valid && ifA.i_rx_ready) begin
            dataQA.push_back(9'(ifA.o_rx_data));
            ferrQA.push_back(ifA.o_frame_err);
            perrQA.push_back(ifA.o_parity_err);
        end
        if (ifA.o_overrun) overrunA = overrunA + 1;
        if (ifB.o_rx_valid && ifB.i_rx_ready) begin
            dataQB.push_back(9'(ifB.o_rx_data));
            ferrQB.push_back(ifB.o_frame_err);
        end
        if (ifB.o_overrun) overrunB = overrunB + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveBit(input bit lineB, input logic value);
        if (lineB) serialB = value;
        else       serialA = value;
        repeat (CPB) @(negedge clk);
    endtask

    // Must be entered on a falling clock edge; leaves the line at the last stop-bit level.
    task automatic applyStimulus(input bit lineB, input logic [8:0] data, input int nBits,
                                 input logic [1:0] stopPat, input logic parBit);
        driveBit(lineB, 1'b0);
        for (int i = 0; i < nBits; i++) driveBit(lineB, data[i]);
        if (PAR_EN) driveBit(lineB, parBit);
        for (int i = 0; i < (lineB ? 2 : 1); i++) driveBit(lineB, stopPat[i]);
    endtask

    initial begin
        int start1, start2, lat1, lat2;
        serialA = 1'b1;
        serialB = 1'b1;
        rstA = 1'b0;
        rstB = 1'b0;
        ifA.i_rx_ready = 1'b1;
        ifB.i_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(ifA.o_rx_valid), 0);
        checkOutput("rst_data", 32'(ifA.o_rx_data), 0);
        checkOutput("rst_ferr", 32'(ifA.o_frame_err), 0);
        checkOutput("rst_perr", 32'(ifA.o_parity_err), 0);
        checkOutput("rst_overrun", 32'(ifA.o_overrun), 0);
        checkOutput("rst_busy", 32'(ifA.o_busy), 0);
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back 0x55 and 0xA3 with ready held high.
        start1 = cycle;
        applyStimulus(1'b0, 9'h055, 8, 2'b11, ^8'h55);
        lat1 = riseA - start1;
        start2 = cycle;
        applyStimulus(1'b0, 9'h0A3, 8, 2'b11, ^8'hA3);
        repeat (2 * CPB) @(negedge clk);
        lat2 = riseA - start2;
        checkOutput("b2b_count", 32'(dataQA.size()), 2);
        checkOutput("b2b_data0", 32'(dataQA[0]), 32'h55);
        checkOutput("b2b_data1", 32'(dataQA[1]), 32'hA3);
        checkOutput("b2b_ferr", 32'({ferrQA[0], ferrQA[1]}), 0);
        checkOutput("b2b_perr", 32'({perrQA[0], perrQA[1]}), 0);
        checkOutput("b2b_lat0", 32'(lat1 >= LAT_NOM - 3 && lat1 <= LAT_NOM + 3), 1);
        checkOutput("b2b_lat1", 32'(lat2 >= LAT_NOM - 3 && lat2 <= LAT_NOM + 3), 1);

        // Short low glitch: receiver enters START then falls back to IDLE.
        serialA = 1'b0;
        repeat (4) @(negedge clk);
        serialA = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("glitch_busy_mid", 32'(ifA.o_busy), 1);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("glitch_busy_end", 32'(ifA.o_busy), 0);
        checkOutput("glitch_count", 32'(dataQA.size()), 2);
        checkOutput("glitch_valid", 32'(ifA.o_rx_valid), 0);

        // Framing error followed by a long break, then a clean frame.
        applyStimulus(1'b0, 9'h03C, 8, 2'b00, ^8'h3C);
        repeat (30 * CPB) @(negedge clk);
        checkOutput("break_busy", 32'(ifA.o_busy), 1);
        checkOutput("break_count", 32'(dataQA.size()), 3);
        serialA = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("break_idle", 32'(ifA.o_busy), 0);
        applyStimulus(1'b0, 9'h07E, 8, 2'b11, ^8'h7E);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("ferr_count", 32'(dataQA.size()), 4);
        checkOutput("ferr_data", 32'(dataQA[2]), 32'h3C);
        checkOutput("ferr_flag", 32'(ferrQA[2]), 1);
        checkOutput("clean_data", 32'(dataQA[3]), 32'h7E);
        checkOutput("clean_flag", 32'(ferrQA[3]), 0);

        // Overrun: consumer stalled across two completions.
        @(posedge clk);
        #1 ifA.i_rx_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 9'h011, 8, 2'b11, ^8'h11);
        applyStimulus(1'b0, 9'h022, 8, 2'b11, ^8'h22);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("ovr_valid", 32'(ifA.o_rx_valid), 1);
        checkOutput("ovr_held", 32'(ifA.o_rx_data), 32'h11);
        checkOutput("ovr_pulses", 32'(overrunA), 1);
        @(posedge clk);
        #1 ifA.i_rx_ready = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        checkOutput("ovr_count", 32'(dataQA.size()), 5);
        checkOutput("ovr_data", 32'(dataQA[4]), 32'h11);
        checkOutput("ovr_drained", 32'(ifA.o_rx_valid), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
        applyStimulus(1'b0, 9'h007, 8, 2'b11, 1'b1);
        applyStimulus(1'b0, 9'h007, 8, 2'b11, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("par_count", 32'(dataQA.size()), 7);
        checkOutput("par_good", 32'(perrQA[5]), 0);
        checkOutput("par_bad", 32'(perrQA[6]), 1);
        checkOutput("par_data", 32'(dataQA[6]), 32'h07);
`endif

        // Instance B: reset mid-data, then a clean 7-bit frame and a bad second stop bit.
        driveBit(1'b1, 1'b0);
        driveBit(1'b1, 1'b0);
        driveBit(1'b1, 1'b1);
        driveBit(1'b1, 1'b0);
        #3;
        checkOutput("b_busy_pre", 32'(ifB.o_busy), 1);
        rstB = 1'b0;
        #1;
        checkOutput("b_rst_busy", 32'(ifB.o_busy), 0);
        checkOutput("b_rst_valid", 32'(ifB.o_rx_valid), 0);
        checkOutput("b_rst_data", 32'(ifB.o_rx_data), 0);
        checkOutput("b_rst_ferr", 32'(ifB.o_frame_err), 0);
        checkOutput("b_rst_overrun", 32'(ifB.o_overrun), 0);
        serialB = 1'b1;
        @(negedge clk);
        rstB = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checkOutput("b_abort_count", 32'(dataQB.size()), 0);
        applyStimulus(1'b1, 9'h05A, 7, 2'b11, ^7'h5A);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("b_count", 32'(dataQB.size()), 1);
        checkOutput("b_data", 32'(dataQB[0]), 32'h5A);
        checkOutput("b_ferr", 32'(ferrQB[0]), 0);
        applyStimulus(1'b1, 9'h02B, 7, 2'b01, ^7'h2B);
        serialB = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("b_stop2_count", 32'(dataQB.size()), 2);
        checkOutput("b_stop2_data", 32'(dataQB[1]), 32'h2B);
        checkOutput("b_stop2_ferr", 32'(ferrQB[1]), 1);
        checkOutput("b_stop2_idle", 32'(ifB.o_busy), 0);
        checkOutput("b_overrun", 32'(overrunB), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
